// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Register map of the fir wishbone slave, ap_ctrl bit
//               positions and the sequencer state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package fir_pkg;

  localparam logic [31:0] c_addr_ap_ctrl = 32'h20;
  localparam logic [31:0] c_addr_len     = 32'h10;
  localparam logic [31:0] c_addr_tap     = 32'h40;

  localparam int c_ap_start_bit = 0;
  localparam int c_ap_done_bit  = 1;
  localparam int c_ap_idle_bit  = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TAP_WR   = 3'd1,
    ST_LEN_WR   = 3'd2,
    ST_START_WR = 3'd3,
    ST_POLL_RD  = 3'd4,
    ST_GAP      = 3'd5,
    ST_FIN      = 3'd6,
    ST_ABORT    = 3'd7
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/fir_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_cfg_sequencer_if
// Description : Wishbone classic single-master bus between the sequencer
//               and the fir slave port.
//   master : drives cyc/stb/we/sel/adr/dat_o, receives dat_i/ack
//   slave  : the mirror view
// Revision    : 1.0  initial release
// ============================================================================
interface fir_cfg_sequencer_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface
`default_nettype wire

// File: rtl/wb_single_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_single_master
// Description : Runs one wishbone access at a time.
//   req/we/adr/dat : launch request, sampled only while no access is active
//   ack_seen       : slave acked in the current cycle (access ends at edge)
//   rdata          : read data, valid with ack_seen
//   timeout        : ACK_TIMEOUT cycles elapsed with no ack (access ends)
//   active         : access in flight (cyc high)
//   wb             : bus master port
// Revision    : 1.0  initial release
// ============================================================================
module wb_single_master #(
  parameter int ACK_TIMEOUT = 255
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        req,
  input  wire logic        we,
  input  wire logic [31:0] adr,
  input  wire logic [31:0] dat,
  output      logic        ack_seen,
  output      logic [31:0] rdata,
  output      logic        timeout,
  output      logic        active,
  fir_cfg_sequencer_if.master wb
);

  localparam int                 c_cnt_w    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ACK_TIMEOUT - 1);

  logic               r_active;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_we;
  logic [31:0]        r_adr;
  logic [31:0]        r_dat;

  // Ack is tested before the timeout so an ack in the expiry cycle wins.
  assign ack_seen = r_active & wb.wbm_ack_i;
  assign timeout  = r_active & ~wb.wbm_ack_i & (r_cnt == c_cnt_last);
  assign rdata    = wb.wbm_dat_i;
  assign active   = r_active;

  assign wb.wbm_cyc_o = r_active;
  assign wb.wbm_stb_o = r_active;
  assign wb.wbm_we_o  = r_we;
  assign wb.wbm_adr_o = r_adr;
  assign wb.wbm_dat_o = r_dat;
  assign wb.wbm_sel_o = 4'b1111;

  // A new request is only accepted while idle, so the edge that ends an
  // access always leaves at least one cycle with cyc low (the gap).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_adr    <= 32'h0;
      r_dat    <= 32'h0;
    end else if (!r_active) begin
      if (req) begin
        r_active <= 1'b1;
        r_cnt    <= '0;
        r_we     <= we;
        r_adr    <= adr;
        r_dat    <= dat;
      end
    end else if (ack_seen || timeout) begin
      r_active <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_cfg_sequencer
// Description : Configures and launches the fir block over wishbone:
//               writes NUM_TAPS taps, the data length and ap_start, then
//               polls ap_ctrl until ap_done.
//   cmd_start/cfg_len : launch pulse and length (ignored while busy)
//   tap_idx/tap_data  : combinational tap lookup by the owner
//   busy/done/err     : status; done is a pulse, err is sticky on timeout
//   wbm               : wishbone master port
// Revision    : 1.0  initial release
// ============================================================================
module fir_cfg_sequencer
  import fir_pkg::*;
#(
  parameter int          NUM_TAPS     = 11,
  parameter logic [31:0] ADDR_AP_CTRL = c_addr_ap_ctrl,
  parameter logic [31:0] ADDR_LEN     = c_addr_len,
  parameter logic [31:0] ADDR_TAP     = c_addr_tap,
  parameter int          ACK_TIMEOUT  = 255
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        cmd_start,
  input  wire logic [31:0] cfg_len,
  output      logic [3:0]  tap_idx,
  input  wire logic [31:0] tap_data,
  output      logic        busy,
  output      logic        done,
  output      logic        err,
  fir_cfg_sequencer_if.master wbm
);

  localparam logic [3:0]  c_last_tap  = 4'(NUM_TAPS - 1);
  localparam logic [31:0] c_done_mask = 32'h1 << c_ap_done_bit;
  localparam logic [31:0] c_start_val = 32'h1 << c_ap_start_bit;

  seq_state_t  r_state;
  logic [3:0]  r_k;
  logic [31:0] r_len;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic        w_req;
  logic        w_we;
  logic [31:0] w_adr;
  logic [31:0] w_dat;
  logic        w_ack_seen;
  logic [31:0] w_rdata;
  logic        w_timeout;
  logic        w_active;
  logic        w_ap_done;

  assign tap_idx   = r_k;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign w_ap_done = |(w_rdata & c_done_mask);

  // Request for the current access state; it is raised whenever the engine
  // is idle, which is exactly the gap cycle after the previous access.
  always_comb begin
    w_req = 1'b0;
    w_we  = 1'b1;
    w_adr = 32'h0;
    w_dat = 32'h0;
    case (r_state)
      ST_TAP_WR: begin
        w_req = ~w_active;
        w_adr = ADDR_TAP + {26'd0, r_k, 2'b00};
        w_dat = tap_data;
      end
      ST_LEN_WR: begin
        w_req = ~w_active;
        w_adr = ADDR_LEN;
        w_dat = r_len;
      end
      ST_START_WR: begin
        w_req = ~w_active;
        w_adr = ADDR_AP_CTRL;
        w_dat = c_start_val;
      end
      ST_POLL_RD: begin
        w_req = ~w_active;
        w_we  = 1'b0;
        w_adr = ADDR_AP_CTRL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_k     <= 4'd0;
      r_len   <= 32'h0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_timeout) begin
        r_state <= ST_ABORT;
        r_err   <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: if (cmd_start) begin
            r_len   <= cfg_len;
            r_err   <= 1'b0;
            r_k     <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= ST_TAP_WR;
          end
          ST_TAP_WR: if (w_ack_seen) begin
            if (r_k == c_last_tap) r_state <= ST_LEN_WR;
            else                   r_k     <= r_k + 4'd1;
          end
          ST_LEN_WR:   if (w_ack_seen) r_state <= ST_START_WR;
          ST_START_WR: if (w_ack_seen) r_state <= ST_POLL_RD;
          ST_POLL_RD: if (w_ack_seen) begin
            if (w_ap_done) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_GAP;
            end
          end
          ST_GAP:   r_state <= ST_POLL_RD;
          ST_FIN:   r_state <= ST_IDLE;
          ST_ABORT: r_state <= ST_IDLE;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  wb_single_master #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_engine (
    .clk      (clk),
    .rst      (rst),
    .req      (w_req),
    .we       (w_we),
    .adr      (w_adr),
    .dat      (w_dat),
    .ack_seen (w_ack_seen),
    .rdata    (w_rdata),
    .timeout  (w_timeout),
    .active   (w_active),
    .wb       (wbm)
  );

endmodule
`default_nettype wire

// File: tb/tb_fir_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_cfg_sequencer
// Description : Testbench for fir_cfg_sequencer with a wishbone slave model
//               and an expected-access list per run.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fir_cfg_sequencer;

  localparam int c_timeout = 255;

  logic        clk;
  logic        rst;
  logic        cmd_start;
  logic [31:0] cfg_len;
  logic [3:0]  tap_idx;
  logic [31:0] tap_data;
  logic        busy;
  logic        done;
  logic        err;

  fir_cfg_sequencer_if wbm ();

  fir_cfg_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_start (cmd_start),
    .cfg_len   (cfg_len),
    .tap_idx   (tap_idx),
    .tap_data  (tap_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .wbm       (wbm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] taps [0:15];
  assign tap_data = taps[tap_idx];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- slave model ----------------
  int s_polls, s_hang, s_lat_fixed;
  int s_cnt, s_acc, s_reads, s_lat;
  bit s_hang_now;

  initial begin
    wbm.wbm_ack_i = 1'b0;
    wbm.wbm_dat_i = 32'h0;
    s_cnt = 0; s_acc = 0; s_reads = 0; s_lat = 0; s_hang_now = 0;
    s_polls = 1; s_hang = -1; s_lat_fixed = 0;
    forever begin
      @(posedge clk);
      #1;
      if (wbm.wbm_cyc_o && wbm.wbm_stb_o) begin
        if (s_cnt == 0) begin
          s_hang_now = (s_acc == s_hang);
          s_acc++;
          s_lat = (s_lat_fixed >= 0) ? s_lat_fixed : int'($urandom_range(0, 3));
        end
        if (!s_hang_now && s_cnt == s_lat) begin
          wbm.wbm_ack_i = 1'b1;
          if (!wbm.wbm_we_o && wbm.wbm_adr_o == 32'h20) begin
            s_reads++;
            // random noise in the other bits; only bit1 means ap_done
            wbm.wbm_dat_i = ($urandom & 32'hFFFF_FFFD) | ((s_reads >= s_polls) ? 32'h2 : 32'h0);
          end else begin
            wbm.wbm_dat_i = $urandom;
          end
        end else begin
          wbm.wbm_ack_i = 1'b0;
        end
        s_cnt++;
      end else begin
        wbm.wbm_ack_i = 1'b0;
        s_cnt = 0;
      end
    end
  end

  // ---------------- expected access list + monitor ----------------
  logic [31:0] e_adr [$];
  logic [31:0] e_dat [$];
  logic        e_we  [$];

  bit mon_en = 0;
  int acc_idx, cur_idx, cyc_len, last_len, done_cnt, poll_reads;
  logic prev_cyc, prev_ackcyc;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("sel_const", 32'(wbm.wbm_sel_o), 32'hF);
      if (wbm.wbm_cyc_o) begin
        if (!prev_cyc) begin
          chk("access_count_in_range", 32'(acc_idx < e_adr.size()), 32'd1);
          chk("busy_during_access", 32'(busy), 32'd1);
          cur_idx = acc_idx;
          acc_idx++;
          cyc_len = 0;
          if (!wbm.wbm_we_o && wbm.wbm_adr_o == 32'h20) poll_reads++;
        end
        cyc_len++;
        chk("stb_with_cyc", 32'(wbm.wbm_stb_o), 32'd1);
        if (cur_idx < e_adr.size()) begin
          chk("access_adr", wbm.wbm_adr_o, e_adr[cur_idx]);
          chk("access_we", 32'(wbm.wbm_we_o), 32'(e_we[cur_idx]));
          if (e_we[cur_idx]) chk("access_dat", wbm.wbm_dat_o, e_dat[cur_idx]);
        end
      end else if (prev_cyc) begin
        last_len = cyc_len;
      end
      if (done) begin
        done_cnt++;
        chk("done_follows_ack", 32'(prev_ackcyc), 32'd1);
        chk("busy_low_with_done", 32'(busy), 32'd0);
      end
      prev_ackcyc = wbm.wbm_cyc_o & wbm.wbm_ack_i;
      prev_cyc    = wbm.wbm_cyc_o;
    end
  end

  task automatic build_expect(input logic [31:0] len, input int polls, input int hang);
    e_adr.delete(); e_dat.delete(); e_we.delete();
    for (int k = 0; k < 11; k++) begin
      e_adr.push_back(32'h40 + 32'(4 * k)); e_dat.push_back(taps[k]); e_we.push_back(1'b1);
    end
    e_adr.push_back(32'h10); e_dat.push_back(len);   e_we.push_back(1'b1);
    e_adr.push_back(32'h20); e_dat.push_back(32'h1); e_we.push_back(1'b1);
    for (int p = 0; p < polls; p++) begin
      e_adr.push_back(32'h20); e_dat.push_back(32'h0); e_we.push_back(1'b0);
    end
    if (hang >= 0)
      while (e_adr.size() > hang + 1) begin
        void'(e_adr.pop_back()); void'(e_dat.pop_back()); void'(e_we.pop_back());
      end
  endtask

  // One sequence from cmd_start to completion, with optional disturbances.
  task automatic run(input int polls, input int hang, input int lat, input bit dup_start,
                     input bit start_in_fin, input bit rst_in_poll);
    logic [31:0] len;
    int cyc_n;
    bit dup_done, aborted_by_rst;
    len = $urandom;
    s_polls = polls; s_hang = hang; s_lat_fixed = lat; s_acc = 0; s_reads = 0;
    build_expect(len, polls, hang);
    acc_idx = 0; cur_idx = 0; cyc_len = 0; last_len = 0; done_cnt = 0; poll_reads = 0;
    prev_cyc = 0; prev_ackcyc = 0;
    mon_en = 1;
    @(negedge clk);
    cmd_start = 1'b1; cfg_len = len;
    cyc_n = 0; dup_done = 0; aborted_by_rst = 0;
    while (cyc_n < 6000) begin
      @(negedge clk);
      cyc_n++;
      cmd_start = 1'b0;
      if (cyc_n == 1) chk("err_cleared_on_start", 32'(err), 32'd0);
      if (rst_in_poll && acc_idx == 14 && wbm.wbm_cyc_o) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cyc", 32'(wbm.wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm.wbm_stb_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        aborted_by_rst = 1;
        break;
      end
      if (dup_start && !dup_done && acc_idx == 4) begin
        cmd_start = 1'b1; cfg_len = ~len; dup_done = 1;
      end
      if (!busy) begin
        if (start_in_fin && done) cmd_start = 1'b1;
        break;
      end
    end
    chk("run_completes", 32'(busy), 32'd0);
    if (busy) begin
      rst = 1'b1; @(negedge clk); rst = 1'b0;
    end
    repeat (6) begin
      @(negedge clk);
      cmd_start = 1'b0;
    end
    mon_en = 0;
    if (!aborted_by_rst) begin
      chk("access_total", 32'(acc_idx), 32'(e_adr.size()));
      chk("done_pulses", 32'(done_cnt), (hang < 0) ? 32'd1 : 32'd0);
      chk("err_final", 32'(err), (hang < 0) ? 32'd0 : 32'd1);
      chk("busy_final", 32'(busy), 32'd0);
      if (hang >= 0) chk("timeout_cyc_len", 32'(last_len), 32'(c_timeout));
      else           chk("poll_reads", 32'(poll_reads), 32'(polls));
    end
  endtask

  initial begin
    logic [31:0] spec_taps [0:10];
    spec_taps = '{32'd0, -32'sd10, -32'sd9, 32'd23, 32'd56, 32'd63, 32'd56, 32'd23, -32'sd9, -32'sd10, 32'd0};
    for (int k = 0; k < 16; k++) taps[k] = 32'h0;
    for (int k = 0; k < 11; k++) taps[k] = spec_taps[k];
    rst = 1'b1; cmd_start = 1'b0; cfg_len = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_cyc", 32'(wbm.wbm_cyc_o), 32'd0);
    chk("reset_stb", 32'(wbm.wbm_stb_o), 32'd0);
    chk("reset_we", 32'(wbm.wbm_we_o), 32'd0);
    chk("reset_adr", wbm.wbm_adr_o, 32'd0);
    chk("reset_dat", wbm.wbm_dat_o, 32'd0);
    chk("reset_sel", 32'(wbm.wbm_sel_o), 32'hF);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_tap_idx", 32'(tap_idx), 32'd0);
    rst = 1'b0;

    // model pins for the reference tap set
    build_expect(32'h64, 3, -1);
    chk("model_size", 32'(e_adr.size()), 32'd16);
    chk("model_tap10_adr", e_adr[10], 32'h68);
    chk("model_tap2_dat", e_dat[2], 32'hFFFF_FFF7);
    chk("model_tap4_dat", e_dat[4], 32'd56);
    chk("model_start_adr", e_adr[12], 32'h20);

    // reference taps, 1-cycle ack, ap_done on the 3rd poll
    run(3, -1, 0, 0, 0, 0);
    chk("ref_poll_reads", 32'(poll_reads), 32'd3);

    // random taps, latencies and poll counts
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 11; k++) taps[k] = $urandom;
      run(int'($urandom_range(1, 5)), -1, -1, 0, 0, 0);
    end

    // 5th tap write never acked, then a normal run clears err
    run(2, 4, -1, 0, 0, 0);
    chk("err_sticky", 32'(err), 32'd1);
    run(1, -1, -1, 0, 0, 0);

    // start pulse while busy, and in the done cycle
    run(2, -1, -1, 1, 0, 0);
    run(2, -1, 0, 0, 1, 0);

    // ack arriving in the last cycle before expiry wins
    run(1, -1, c_timeout - 1, 0, 0, 0);

    // reset during the first poll, then a fresh sequence from tap 0
    run(3, -1, 1, 0, 0, 1);
    run(2, -1, -1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
